// File: rtl/uart_transmitter.sv
// UART serial transmit stage: pops one FIFO word and sends start, 5-8 data bits (LSB first),
// optional parity and 1-2 stop bits, timed by the oversampling tick.
module uart_transmitter #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ov_baud_rt_i,
    input  logic       tx_req_i,
    input  logic [7:0] data_tx_i,
    input  logic [1:0] data_width_i,
    input  logic [1:0] parity_mode_i,
    input  logic [1:0] stop_bits_i,
    output logic       tx_ack_o,
    output logic       tx_o,
    output logic       tx_done_o,
    output logic       tx_idle_o
);

    localparam logic [1:0] PAR_EVEN  = 2'd0;
    localparam logic [1:0] PAR_ODD   = 2'd1;
    localparam logic [1:0] SB_2BIT   = 2'd1;
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e     r_state;
    logic [7:0] r_shift;
    logic [1:0] r_width;
    logic       r_par_en;
    logic       r_par_bit;
    logic       r_two_stop;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic       r_tx;
    logic       r_done;
    logic       r_idle;

    logic       w_accept;
    logic       w_bit_end;
    logic [7:0] w_mask;
    logic       w_par;

    assign w_accept  = !rst_i && (r_state == StIdle) && tx_req_i;
    assign w_bit_end = ov_baud_rt_i && (r_tick_cnt == LAST_TICK);
    // Parity covers only the bits that will actually be shifted out.
    assign w_mask    = 8'hFF >> (2'd3 - data_width_i);
    assign w_par     = (^(data_tx_i & w_mask)) ^ (parity_mode_i == PAR_ODD);

    assign tx_ack_o  = w_accept;
    assign tx_o      = r_tx;
    assign tx_done_o = r_done;
    assign tx_idle_o = r_idle;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_width    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_idle     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state != StIdle && ov_baud_rt_i) begin
                r_tick_cnt <= w_bit_end ? 4'd0 : r_tick_cnt + 4'd1;
            end
            unique case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (tx_req_i) begin
                        r_shift    <= data_tx_i;
                        r_width    <= data_width_i;
                        r_par_en   <= (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
                        r_par_bit  <= w_par;
                        r_two_stop <= (stop_bits_i == SB_2BIT);
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_idle     <= 1'b0;
                        r_state    <= StStart;
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= StData;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == {1'b0, r_width} + 3'd4) begin
                            r_bit_cnt <= '0;
                            if (r_par_en) begin
                                r_tx    <= r_par_bit;
                                r_state <= StParity;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= StStop;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                StParity: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= StStop;
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        // r_bit_cnt doubles as the stop-bit index.
                        if (r_two_stop && r_bit_cnt == 3'd0) begin
                            r_bit_cnt <= 3'd1;
                        end else begin
                            r_done  <= 1'b1;
                            r_idle  <= 1'b1;
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: directed frames with hand-computed line sequences,
// checked by a monitor that decodes the serial line against the oversampling tick.
module tb_uart_transmitter;

    typedef struct {
        int          n;
        logic [11:0] bits;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       req;
    logic [7:0] data;
    logic [1:0] dw;
    logic [1:0] pm;
    logic [1:0] sb;
    logic       tx_ack;
    logic       tx_line;
    logic       tx_done;
    logic       tx_idle;

    frame_t     exp_q[$];
    logic [7:0] fifo_q[$];

    int n_vec = 0;
    int n_err = 0;

    bit          m_active = 1'b0;
    int          m_ticks = 0;
    int          m_nbits = 0;
    logic [11:0] m_bits = '0;
    int          n_ack = 0;
    int          n_done = 0;
    int          b2b_hits = 0;
    bit          ack_pulse = 1'b0;

    always #5 clk = ~clk;

    uart_transmitter #(.OVERSAMPLE(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ov_baud_rt_i  (tick),
        .tx_req_i      (req),
        .data_tx_i     (data),
        .data_width_i  (dw),
        .parity_mode_i (pm),
        .stop_bits_i   (sb),
        .tx_ack_o      (tx_ack),
        .tx_o          (tx_line),
        .tx_done_o     (tx_done),
        .tx_idle_o     (tx_idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_vec++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req_v);
        end
    endtask

    // lit is written in line order, first bit on the left.
    task automatic push_exp(input int n, input logic [11:0] lit);
        frame_t f;
        f.n    = n;
        f.bits = '0;
        for (int i = 0; i < n; i++) f.bits[i] = lit[n - 1 - i];
        exp_q.push_back(f);
    endtask

    task automatic set_cfg(input logic [1:0] w, input logic [1:0] p, input logic [1:0] s);
        dw = w;
        pm = p;
        sb = s;
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !m_active) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: frames still pending after %0d cycles, required none", budget);
    endtask

    task automatic wait_in_data(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (m_active && m_nbits >= 3) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL data_timeout: frame did not reach DATA within %0d cycles", budget);
    endtask

    // Driver: free-running tick every 4 clk, FIFO head presented on req/data.
    initial begin
        int phase;
        phase = 0;
        tick  = 1'b0;
        req   = 1'b0;
        data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (ack_pulse) begin
                ack_pulse = 1'b0;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            tick  = (phase == 3);
            phase = (phase + 1) % 4;
            req   = (fifo_q.size() > 0);
            data  = req ? fifo_q[0] : 8'h00;
        end
    end

    // Monitor: samples mid-cycle; bit i is sampled on the 8th tick of bit i.
    initial begin
        frame_t e;
        bit     done_now;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_active = 1'b0;
            end else begin
                done_now = 1'b0;
                if (tx_done) begin
                    done_now = 1'b1;
                    n_done++;
                    if (!m_active) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_done: tx_done_o=1 with no frame, required 0");
                    end else begin
                        m_active = 1'b0;
                        chk("done_idle", 32'(tx_idle), 32'd1);
                        chk("done_line", 32'(tx_line), 32'd1);
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_frame: bits %0h with none expected", m_bits);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_nbits", 32'(m_nbits), 32'(e.n));
                            chk("frame_bits", 32'(m_bits), 32'(e.bits));
                            chk("frame_ticks", 32'(m_ticks), 32'(16 * e.n));
                        end
                    end
                end else if (m_active) begin
                    if (tick && (m_ticks % 16) == 7) begin
                        if (m_nbits < 12) m_bits[m_nbits] = tx_line;
                        if (m_nbits == 0) chk("busy_idle", 32'(tx_idle), 32'd0);
                        m_nbits++;
                    end
                    if (tick) m_ticks++;
                    if (m_ticks > 16 * 13) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL runaway_frame: %0d ticks without tx_done_o", m_ticks);
                        m_active = 1'b0;
                    end
                end
                if (tx_ack) begin
                    n_ack++;
                    ack_pulse = 1'b1;
                    if (m_active) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL double_ack: tx_ack_o=1 mid-frame, required 0");
                    end
                    if (done_now) b2b_hits++;
                    m_active = 1'b1;
                    m_ticks  = 0;
                    m_nbits  = 0;
                    m_bits   = '0;
                end
            end
        end
    end

    initial begin
        int b0;
        int d0;
        rst = 1'b1;
        set_cfg(2'd3, 2'd0, 2'd0);

        // 8E1 0x55, queued while still in reset so ack must stay low.
        push_exp(11, 12'b01010101001);
        fifo_q.push_back(8'h55);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", 32'(tx_line), 32'd1);
        chk("reset_ack", 32'(tx_ack), 32'd0);
        chk("reset_done", 32'(tx_done), 32'd0);
        chk("reset_idle", 32'(tx_idle), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_drained(2000);

        // 5O2 0xFF: upper bits masked, odd parity 0.
        set_cfg(2'd0, 2'd1, 2'd1);
        push_exp(9, 12'b011111011);
        fifo_q.push_back(8'hFF);
        wait_drained(2000);

        // 7 bits, DISABLED2, RESERVED1 stop -> 7N1.
        set_cfg(2'd2, 2'd3, 2'd2);
        push_exp(9, 12'b010000011);
        fifo_q.push_back(8'h41);
        wait_drained(2000);

        // Back-to-back 8E1 0xA3, 0x0F.
        set_cfg(2'd3, 2'd0, 2'd0);
        b0 = b2b_hits;
        push_exp(11, 12'b01100010101);
        push_exp(11, 12'b01111000001);
        fifo_q.push_back(8'hA3);
        fifo_q.push_back(8'h0F);
        wait_drained(4000);
        chk("b2b_gap", 32'(b2b_hits - b0), 32'd1);

        // Config change mid-frame: 0x80 stays 8E1, next 0x80 goes out 5O2.
        push_exp(11, 12'b00000000111);
        fifo_q.push_back(8'h80);
        wait_in_data(2000);
        set_cfg(2'd0, 2'd1, 2'd1);
        push_exp(9, 12'b000000111);
        fifo_q.push_back(8'h80);
        wait_drained(4000);

        // Reset during DATA abandons the frame.
        set_cfg(2'd3, 2'd0, 2'd0);
        d0 = n_done;
        fifo_q.push_back(8'h3C);
        wait_in_data(2000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", 32'(tx_line), 32'd1);
        chk("midrst_idle", 32'(tx_idle), 32'd1);
        repeat (800) @(posedge clk);
        chk("midrst_no_done", 32'(n_done - d0), 32'd0);
        push_exp(11, 12'b00101101001);
        fifo_q.push_back(8'h5A);
        wait_drained(2000);

        chk("ack_count", 32'(n_ack), 32'd9);
        chk("done_count", 32'(n_done), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART controller. Pops one word from the TX FIFO and shifts it out on the TX line as a frame: start bit, 5–8 data bits (LSB first), an optional even/odd parity bit, and 1 or 2 stop bits. Bit timing comes from the 16× oversampling tick of the baud rate generator. Data width, parity mode and stop-bit codes are the package configuration codes. The block raises the TX-done event that the interrupt arbiter reports as `INT_TX_DONE`.

## Interface

Parameters:
- `OVERSAMPLE`, 16: oversampling ticks per bit. Must be a power of two, 2..16.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `ov_baud_rt_i`  in  1  oversampling tick, one-cycle pulse.
- `tx_req_i`  in  1  TX FIFO holds a word (not empty).
- `data_tx_i`  in  8  word at the FIFO head.
- `data_width_i`  in  2  `DW_5BIT`..`DW_8BIT`.
- `parity_mode_i`  in  2  `EVEN`, `ODD`, `DISABLED1`/`DISABLED2`.
- `stop_bits_i`  in  2  `SB_1BIT`, `SB_2BIT`; `RESERVED1`/`RESERVED2` are treated as `SB_1BIT`.
- `tx_ack_o`  out  1  one-cycle FIFO pop strobe.
- `tx_o`  out  1  serial line, idle high.
- `tx_done_o`  out  1  one-cycle pulse at the end of each frame.
- `tx_idle_o`  out  1  high in IDLE.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx_o`=1.
  - If `tx_req_i`=1 the frame is accepted:
    - latch `data_tx_i` into the shift register;
    - latch all three config inputs into frame-local registers;
    - pulse `tx_ack_o` in the same cycle;
    - clear the tick counter and bit counter;
    - go to START.
- **Config isolation:** config inputs are sampled only at acceptance. Changes mid-frame have no effect until the next frame.
- **Bit period:** a 4-bit tick counter increments on each `ov_baud_rt_i`. The bit ends on the tick that brings the count to `OVERSAMPLE`; the counter then wraps to 0 and the FSM advances.
- **START:** `tx_o`=0 for one bit period, then DATA.
- **DATA**
  - `tx_o` = shift register bit 0; shift right at each bit end.
  - Bits sent = 5 + latched width code. Bits above the width are never sent.
  - After the last bit: go to PARITY if parity is enabled, otherwise STOP.
- **Parity value**
  - `EVEN`: XOR of the transmitted bits only (bits above the width are masked).
  - `ODD`: the complement of the `EVEN` value.
  - Computed from the latched word at acceptance.
- **PARITY:** one bit period, then STOP.
- **STOP**
  - `tx_o`=1 for 1 or 2 bit periods.
  - At the end of the last stop bit: pulse `tx_done_o` for one cycle and go to IDLE.
- **Back-to-back:** if `tx_req_i` is high on the first IDLE cycle, the next frame is accepted immediately. The inter-frame gap is a single clk cycle of `tx_o`=1.
- **Reset** (applies to every output, including mid-frame)
  - `tx_o`=1, `tx_ack_o`=0, `tx_done_o`=0, `tx_idle_o`=1; FSM in IDLE; counters at 0.
  - A reset mid-frame abandons the frame with no `tx_done_o` and no additional `tx_ack_o`.

## Timing

- **Acceptance to line:**
  - Cycle A: `tx_req_i`=1 in IDLE and `tx_ack_o`=1.
  - `tx_o` falls at A+1 (registered output).
- **Bit duration:** exactly `OVERSAMPLE` ticks, measured from the cycle after the bit started to the cycle after its last tick.
- **Frame length** in bit periods = 1 + (5..8) + (0|1) + (1|2), i.e. 7..12 bits.
- **`tx_done_o`:** asserted in the cycle after the final stop-bit tick, coincident with the return of `tx_idle_o`=1.
- **Registered outputs:** `tx_o`, `tx_done_o` and `tx_idle_o` are registered. `tx_ack_o` is combinational from IDLE && `tx_req_i`.
- **Tick during acceptance:** a tick in the acceptance cycle is not counted; counting starts at A+1.
- **Simultaneous events:**
  - `tx_req_i` arriving while a frame is in progress is ignored until IDLE.
  - A tick and reset in the same cycle: reset wins.

## Test plan

- **Default 8E1:** tick every 4 clk; config `DW_8BIT`/`EVEN`/`SB_1BIT`; send `0x55`.
  - Required line sequence: 0, 1,0,1,0,1,0,1,0, 0, 1.
  - Each bit lasts 64 clk.
  - Exactly one `tx_ack_o` and one `tx_done_o`, 704 clk apart.
- **5O2, masking and odd parity:** `DW_5BIT`/`ODD`/`SB_2BIT`; send `0xFF`.
  - Required line sequence: 0, 1,1,1,1,1, 0, 1,1 (9 bits).
  - Upper three data bits must not appear on the line.
- **7N1 with `DISABLED2` and reserved stop code:** `DW_7BIT`, parity `DISABLED2`, stop `RESERVED1`; send `0x41`.
  - Required line sequence: 0, 1,0,0,0,0,0,1, 1 (9 bits, no parity bit).
- **Back-to-back:** FIFO holds `0xA3` and `0x0F`, `tx_req_i` held high.
  - Two `tx_ack_o` pulses, two frames.
  - Exactly 1 clk of idle-high between them.
  - Frame contents correct for each word.
- **Config change mid-frame:** start an 8E1 frame of `0x80`; during DATA switch to `DW_5BIT`/`ODD`/`SB_2BIT`.
  - Current frame stays 8E1 (parity bit 1, one stop bit).
  - The next frame uses the new config.
- **Reset mid-frame:** assert `rst_i` for 1 cycle during the DATA state.
  - `tx_o`=1 and `tx_idle_o`=1 on the next cycle.
  - No `tx_done_o` pulse.
  - The next `tx_req_i` starts a clean frame.
